shot_scheduler: RTL and testbench
=================================

# shot_scheduler

Owns the shared pool of bullet slots for the tank game. It arbitrates fire requests from the player tank and the enemy tank, allocates free slots, and advances every live bullet once per video frame. It retires bullets that leave the screen, and answers per-pixel "is a bullet here" queries from the VGA renderer. It sits between the player/enemy tank logic and the VGA block and runs on the pixel clock domain.

## Interface
- SLOTS, 4: number of bullet slots; each is 1 valid bit, 1 owner bit, and 10-bit x and 10-bit y.
- MAX_PER, 2: maximum live bullets per owner (player or enemy).
- STEP, 4: pixels moved per frame_tick.
- SIZE, 4: bullet square edge in pixels.
- SCREEN_H, 480: vertical extent in pixels; valid y range is 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- fire_p  in  1  player fire request (level, debounced).
- p_x, p_y  in  10 each  player muzzle position; sampled at grant.
- fire_e  in  1  enemy fire request (level).
- e_x, e_y  in  10 each  enemy muzzle position; sampled at grant.
- grant_p, grant_e  out  1 each  one-cycle grant pulses.
- query_x, query_y  in  10 each  current pixel coordinates from the VGA block.
- hit  out  1  a live bullet covers the queried pixel.
- hit_owner  out  1  owner of that bullet: 0 = player, 1 = enemy.
- active  out  SLOTS  valid bit per slot.

## Operation
- **Arming**
  - Each requester has an arm bit.
  - The arm bit is cleared by reset and by that requester's grant.
  - The arm bit is set on any cycle its fire input is sampled low.
  - A requester is eligible when fire=1, armed=1, owner count < MAX_PER, and at least one slot is free.
- **Arbitration**
  - At most one grant per cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, a round-robin pointer decides; reset value 0 = player.
  - The pointer flips to the loser only after a contested grant. Uncontested grants leave it unchanged.
- **Allocation**
  - The winner takes the lowest-index free slot.
  - The slot loads valid=1, the owner, and the muzzle x,y unmodified.
  - The owner count increments.
- **Movement on frame_tick**, applied to every valid slot not being allocated this cycle:
  - Player bullets: if y < STEP, retire the slot (valid=0, player count -1); else y = y - STEP.
  - Enemy bullets: if y + STEP >= SCREEN_H, retire the slot; else y = y + STEP.
  - Compute y + STEP with 11 bits so it cannot wrap.
  - x never changes.
- **Simultaneous events**
  - A slot retired on frame_tick is not reusable until the next cycle.
  - A grant and a retirement of the same owner in one cycle leave that owner's count unchanged.
  - Counts are checked against the pre-update value.
- **Hit query**
  - A slot matches when it is valid, query_x is in [x, x+SIZE-1], and query_y is in [y, y+SIZE-1].
  - Compare with 11-bit sums.
  - hit = OR over all matching slots.
  - hit_owner = owner of the lowest-index matching slot; it is 0 when there is no match.
- **Reset**, at any time including mid-frame or mid-grant:
  - All slots invalid, counts 0, arm bits 0, pointer 0.
  - grant_p=0, grant_e=0, hit=0, hit_owner=0, active=0.

## Timing
- fire sampled at edge N: slot state and grant_x are registered at edge N, so grant is visible in cycle N+1 for exactly one cycle.
- A held request produces exactly one grant. The next grant needs fire low for at least one cycle, then high again.
- active reflects slot valid bits registered; it updates the same edge as allocation or retirement.
- hit/hit_owner: 1-cycle latency from query_x/query_y. The VGA block delays its pixel pipeline one cycle to match.
- frame_tick effect: positions update on the edge sampling frame_tick. Queries in the following cycle see the new positions.

## Test plan
- **Single player shot:** reset, fire_p=1 held 10 cycles with p=(100,200).
  - Expect exactly one grant_p, one cycle after fire_p is sampled high.
  - Expect slot0 = (100,200,owner 0) and active=0001.
- **Contention:** both fires rise the same cycle from reset.
  - Expect grant_p first.
  - After both drop and rise together again, expect grant_e; the pointer alternates.
- **Per-owner limit:** player fires 3 times (each with a low gap).
  - Expect 2 grants only; the third request stays pending.
  - After one player bullet retires, the pending request is granted.
- **Retirement:** player bullet at y=5, frame_tick.
  - Expect y=1. On the next frame_tick, expect valid=0 and active bit clear.
  - Enemy bullet at y=474 with one frame_tick: 478 >= 480 is false, so expect y=478. On the next tick, expect retire.
- **Pool full:** 2 player + 2 enemy bullets live, enemy fire again.
  - Expect no grant.
  - On a frame_tick that retires one slot while fire_e is held: expect no grant that cycle, and a grant on the next.
- **Hit query:** slots at (100,200,player) and (102,202,enemy), query (103,203).
  - Expect hit=1 and hit_owner=0 one cycle later.
  - Query (99,200): expect hit=0.
  - Assert rst mid-stream: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/shot_scheduler.sv
// Bullet slot pool for the tank game: arbitrates player/enemy fire, moves bullets each frame, answers pixel hit queries.
// Grants and slot state register on the sampling edge; hit/hit_owner have one cycle of latency.
module shot_scheduler #(
  parameter int SLOTS    = 4,
  parameter int MAX_PER  = 2,
  parameter int STEP     = 4,
  parameter int SIZE     = 4,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             fire_p,
  input  logic [9:0]       p_x,
  input  logic [9:0]       p_y,
  input  logic             fire_e,
  input  logic [9:0]       e_x,
  input  logic [9:0]       e_y,
  output logic             grant_p,
  output logic             grant_e,
  input  logic [9:0]       query_x,
  input  logic [9:0]       query_y,
  output logic             hit,
  output logic             hit_owner,
  output logic [SLOTS-1:0] active
);

  localparam int CW = $clog2(MAX_PER + 1);
  localparam int RW = $clog2(SLOTS + 1);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOTS-1:0] vld_q, vld_d;
  logic [SLOTS-1:0] own_q, own_d;
  logic [9:0]       x_q [SLOTS];
  logic [9:0]       x_d [SLOTS];
  logic [9:0]       y_q [SLOTS];
  logic [9:0]       y_d [SLOTS];
  logic [CW-1:0]    cnt_p_q, cnt_p_d, cnt_e_q, cnt_e_d;
  logic             arm_p_q, arm_p_d, arm_e_q, arm_e_d;
  logic             ptr_q, ptr_d;
  logic             grant_p_q, grant_e_q;
  logic             hit_q, hit_d, hit_own_q, hit_own_d;

  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic             elig_p, elig_e, win_p, win_e;
  logic [RW-1:0]    ret_p, ret_e;
  logic [10:0]      ysum;

  // Free slots exclude anything retiring this cycle because vld_q is the pre-update view.
  always_comb begin
    free_any = ~&vld_q;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    elig_p = fire_p & arm_p_q & (cnt_p_q < CW'(MAX_PER)) & free_any;
    elig_e = fire_e & arm_e_q & (cnt_e_q < CW'(MAX_PER)) & free_any;
    win_p  = elig_p & (~elig_e | ~ptr_q);
    win_e  = elig_e & (~elig_p |  ptr_q);
    // Pointer moves to the loser only when both were eligible.
    ptr_d   = (elig_p & elig_e) ? win_p : ptr_q;
    arm_p_d = win_p ? 1'b0 : (~fire_p | arm_p_q);
    arm_e_d = win_e ? 1'b0 : (~fire_e | arm_e_q);
  end

  always_comb begin
    vld_d = vld_q;
    own_d = own_q;
    ret_p = '0;
    ret_e = '0;
    ysum  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      ysum   = {1'b0, y_q[i]} + 11'(STEP);
      if ((win_p | win_e) && (IW'(i) == free_idx)) begin
        vld_d[i] = 1'b1;
        own_d[i] = win_e;
        x_d[i]   = win_e ? e_x : p_x;
        y_d[i]   = win_e ? e_y : p_y;
      end else if (frame_tick && vld_q[i]) begin
        if (!own_q[i]) begin
          if (y_q[i] < 10'(STEP)) begin
            vld_d[i] = 1'b0;
            ret_p    = ret_p + RW'(1);
          end else begin
            y_d[i] = y_q[i] - 10'(STEP);
          end
        end else begin
          if (ysum >= 11'(SCREEN_H)) begin
            vld_d[i] = 1'b0;
            ret_e    = ret_e + RW'(1);
          end else begin
            y_d[i] = ysum[9:0];
          end
        end
      end
    end
    cnt_p_d = cnt_p_q + CW'(win_p) - CW'(ret_p);
    cnt_e_d = cnt_e_q + CW'(win_e) - CW'(ret_e);
  end

  always_comb begin
    logic [10:0] qx, qy, sx, sy;
    logic        m;
    hit_d     = 1'b0;
    hit_own_d = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      qx = {1'b0, query_x};
      qy = {1'b0, query_y};
      sx = {1'b0, x_q[i]};
      sy = {1'b0, y_q[i]};
      m  = vld_q[i] & (qx >= sx) & (qx <= sx + 11'(SIZE - 1))
                    & (qy >= sy) & (qy <= sy + 11'(SIZE - 1));
      if (m) begin
        hit_d     = 1'b1;
        hit_own_d = own_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      own_q     <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cnt_p_q   <= '0;
      cnt_e_q   <= '0;
      arm_p_q   <= 1'b0;
      arm_e_q   <= 1'b0;
      ptr_q     <= 1'b0;
      grant_p_q <= 1'b0;
      grant_e_q <= 1'b0;
      hit_q     <= 1'b0;
      hit_own_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      own_q     <= own_d;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      cnt_p_q   <= cnt_p_d;
      cnt_e_q   <= cnt_e_d;
      arm_p_q   <= arm_p_d;
      arm_e_q   <= arm_e_d;
      ptr_q     <= ptr_d;
      grant_p_q <= win_p;
      grant_e_q <= win_e;
      hit_q     <= hit_d;
      hit_own_q <= hit_own_d;
    end
  end

  assign grant_p   = grant_p_q;
  assign grant_e   = grant_e_q;
  assign hit       = hit_q;
  assign hit_owner = hit_own_q;
  assign active    = vld_q;

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: grants, contention, limits, retirement, pool full, hit queries, reset.
module tb_shot_scheduler;
  logic       clk = 1'b0;
  logic       rst, frame_tick, fire_p, fire_e;
  logic [9:0] p_x, p_y, e_x, e_y, query_x, query_y;
  logic       grant_p, grant_e, hit, hit_owner;
  logic [3:0] active;
  int         total = 0;
  int         bad   = 0;
  int         g;

  shot_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .fire_p(fire_p), .p_x(p_x), .p_y(p_y),
    .fire_e(fire_e), .e_x(e_x), .e_y(e_y),
    .grant_p(grant_p), .grant_e(grant_e),
    .query_x(query_x), .query_y(query_y),
    .hit(hit), .hit_owner(hit_owner), .active(active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reset, then one idle cycle with fires low so both requesters arm.
  task automatic do_reset();
    rst = 1'b1; fire_p = 1'b0; fire_e = 1'b0; frame_tick = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; fire_p = 1'b0; fire_e = 1'b0;
    p_x = '0; p_y = '0; e_x = '0; e_y = '0; query_x = '0; query_y = '0;
    step(); step();
    chk("rst_grant_p", grant_p, 0);
    chk("rst_grant_e", grant_e, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_owner", hit_owner, 0);
    chk("rst_active", active, 0);

    // single player shot, fire held 10 cycles
    do_reset();
    p_x = 10'd100; p_y = 10'd200; fire_p = 1'b1;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) chk("t1_first_grant", grant_p, 1);
      g += int'(grant_p);
    end
    chk("t1_grant_count", g, 1);
    chk("t1_active", active, 4'b0001);
    chk("t1_x", dut.x_q[0], 100);
    chk("t1_y", dut.y_q[0], 200);
    chk("t1_owner", dut.own_q[0], 0);
    fire_p = 1'b0;

    // contention alternates through the round-robin pointer
    do_reset();
    fire_p = 1'b1; fire_e = 1'b1; step();
    chk("t2_c1_p", grant_p, 1);
    chk("t2_c1_e", grant_e, 0);
    fire_p = 1'b0; fire_e = 1'b0; step();
    fire_p = 1'b1; fire_e = 1'b1; step();
    chk("t2_c2_p", grant_p, 0);
    chk("t2_c2_e", grant_e, 1);
    fire_p = 1'b0; fire_e = 1'b0; step();
    fire_p = 1'b1; fire_e = 1'b1; step();
    chk("t2_c3_p", grant_p, 1);
    chk("t2_c3_e", grant_e, 0);
    fire_p = 1'b0; fire_e = 1'b0;

    // per-owner limit; pending request granted after a retirement
    do_reset();
    p_x = 10'd10; p_y = 10'd2; fire_p = 1'b1; step();
    chk("t3_g1", grant_p, 1);
    fire_p = 1'b0; step();
    p_y = 10'd100; fire_p = 1'b1; step();
    chk("t3_g2", grant_p, 1);
    fire_p = 1'b0; step();
    fire_p = 1'b1;
    g = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      g += int'(grant_p);
    end
    chk("t3_blocked", g, 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t3_tick_grant", grant_p, 0);
    chk("t3_tick_active", active, 4'b0010);
    step();
    chk("t3_pending_grant", grant_p, 1);
    chk("t3_pending_active", active, 4'b0011);
    chk("t3_slot1_y", dut.y_q[1], 96);
    fire_p = 1'b0;

    // retirement at both screen edges
    do_reset();
    p_x = 10'd50; p_y = 10'd5; fire_p = 1'b1; step(); fire_p = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_p_y", dut.y_q[0], 1);
    chk("t4_p_live", active, 4'b0001);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_p_retired", active, 4'b0000);
    e_x = 10'd60; e_y = 10'd474; fire_e = 1'b1; step(); fire_e = 1'b0;
    chk("t4_e_grant", grant_e, 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_e_y", dut.y_q[0], 478);
    chk("t4_e_live", active, 4'b0001);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t4_e_retired", active, 4'b0000);

    // pool full, then a retirement frees a slot one cycle later
    do_reset();
    p_x = 10'd20; p_y = 10'd300;
    fire_p = 1'b1; step(); fire_p = 1'b0; step();
    fire_p = 1'b1; step(); fire_p = 1'b0;
    e_x = 10'd30; e_y = 10'd476;
    fire_e = 1'b1; step(); fire_e = 1'b0; step();
    e_y = 10'd100;
    fire_e = 1'b1; step();
    chk("t5_full", active, 4'b1111);
    fire_e = 1'b0; step();
    fire_e = 1'b1; step();
    chk("t5_no_grant1", grant_e, 0);
    step();
    chk("t5_no_grant2", grant_e, 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("t5_tick_grant", grant_e, 0);
    chk("t5_tick_active", active, 4'b1011);
    step();
    chk("t5_next_grant", grant_e, 1);
    chk("t5_next_active", active, 4'b1111);
    chk("t5_slot2_y", dut.y_q[2], 100);
    fire_e = 1'b0;

    // hit queries over overlapping bullets, then reset mid-stream
    do_reset();
    p_x = 10'd100; p_y = 10'd200; fire_p = 1'b1; step(); fire_p = 1'b0;
    e_x = 10'd102; e_y = 10'd202; fire_e = 1'b1; step(); fire_e = 1'b0;
    chk("t6_active", active, 4'b0011);
    query_x = 10'd103; query_y = 10'd203; step();
    chk("t6_q1_hit", hit, 1);
    chk("t6_q1_owner", hit_owner, 0);
    query_x = 10'd99; query_y = 10'd200; step();
    chk("t6_q2_hit", hit, 0);
    chk("t6_q2_owner", hit_owner, 0);
    query_x = 10'd105; query_y = 10'd205; step();
    chk("t6_q3_hit", hit, 1);
    chk("t6_q3_owner", hit_owner, 1);
    query_x = 10'd104; query_y = 10'd200; step();
    chk("t6_q4_hit", hit, 0);
    query_x = 10'd103; query_y = 10'd203; fire_p = 1'b1; rst = 1'b1; step();
    chk("t6_rst_grant_p", grant_p, 0);
    chk("t6_rst_grant_e", grant_e, 0);
    chk("t6_rst_hit", hit, 0);
    chk("t6_rst_owner", hit_owner, 0);
    chk("t6_rst_active", active, 0);
    rst = 1'b0; fire_p = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
